// File: rtl/demux_pkg.sv
// Shared select encoding and channel decode for the 1x4 stream demux.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_CH3 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CH2 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CH1 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CH0 = 2'b11;

  // Select value to channel index; same encoding as the 4-to-1 selector.
  function automatic logic [SEL_W-1:0] sel_to_ch(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL_CH3: return 2'd3;
      SEL_CH2: return 2'd2;
      SEL_CH1: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: holding register, valid flag (EMPTY/FULL) and
// delivered-word counter.
//   clk, rstb      : clock, async active-low reset
//   flush          : sync clear of valid; data and cnt are kept
//   load, in_data  : write strobe and word from the top-level decode
//   out_ready      : consumer accepts the held word this cycle
//   data, valid    : held word and its valid flag
//   cnt            : words delivered, wrapping
//   can_load       : slot is empty or drains this cycle (combinational)
module demux_out_slot #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             can_load
);

  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             drain;

  assign can_load = ~valid | out_ready;
  assign drain    = valid & out_ready & ~flush;

  // Next-state: flush wins over drain and load; refill on drain keeps valid.
  always_comb begin
    data_nxt  = data;
    valid_nxt = valid;
    cnt_nxt   = cnt;
    if (flush) begin
      valid_nxt = 1'b0;
    end else begin
      if (drain) begin
        valid_nxt = 1'b0;
        cnt_nxt   = cnt + CNT_W'(1);
      end
      if (load) begin
        data_nxt  = in_data;
        valid_nxt = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      data  <= data_nxt;
      valid <= valid_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with per-channel handshakes and
// delivered-word counters.
//   clk, rstb           : clock, async active-low reset
//   flush               : sync clear of all holding registers' valid flags
//   in_data/in_sel      : input word and destination (00->ch3 .. 11->ch0)
//   in_valid/in_ready   : input handshake; in_ready is combinational from
//                         in_sel, flush, rstb and out_ready
//   out_data3..0        : holding-register contents
//   out_valid/out_ready : per-channel output handshake, bit n = channel n
//   cnt3..0             : words delivered per channel, wrapping
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              flush,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data3,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data0,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  cnt3,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt0
);

  logic [SEL_W-1:0]  ch;
  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt  [NUM_CH];

  assign ch       = sel_to_ch(in_sel);
  assign in_ready = rstb & ~flush & can_load[ch];

  // One-hot load strobe for the decoded channel.
  always_comb begin
    load     = '0;
    load[ch] = in_valid & in_ready;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rstb      (rstb),
      .flush     (flush),
      .load      (load[n]),
      .in_data   (in_data),
      .out_ready (out_ready[n]),
      .data      (slot_data[n]),
      .valid     (out_valid[n]),
      .cnt       (slot_cnt[n]),
      .can_load  (can_load[n])
    );
  end

  assign out_data3 = slot_data[3];
  assign out_data2 = slot_data[2];
  assign out_data1 = slot_data[1];
  assign out_data0 = slot_data[0];
  assign cnt3      = slot_cnt[3];
  assign cnt2      = slot_cnt[2];
  assign cnt1      = slot_cnt[1];
  assign cnt0      = slot_cnt[0];

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: vector table plus scoreboard.
module tb_demux_1x4_stream;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rstb;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data3, out_data2, out_data1, out_data0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt3, cnt2, cnt1, cnt0;

  logic [WIDTH-1:0] od [4];
  logic [CNT_W-1:0] oc [4];

  int tests;
  int fails;

  demux_1x4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data3 (out_data3),
    .out_data2 (out_data2),
    .out_data1 (out_data1),
    .out_data0 (out_data0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt3      (cnt3),
    .cnt2      (cnt2),
    .cnt1      (cnt1),
    .cnt0      (cnt0)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = cnt0;
  assign oc[1] = cnt1;
  assign oc[2] = cnt2;
  assign oc[3] = cnt3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk)
    if (rstb && in_valid)
      assert (!$isunknown(in_sel)) else $error("in_sel unknown while in_valid is high");

  // Scoreboard: one queue per channel holding the word the slot should contain.
  logic [WIDTH-1:0] q [4][$];
  logic [WIDTH-1:0] data_m [4];
  logic [CNT_W-1:0] cnt_m [4];

  function automatic int ch_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  // Monitor at the falling edge: compare state, then predict the next rising edge.
  always @(negedge clk) begin
    int c;
    logic er;
    logic [WIDTH-1:0] w;
    if (!rstb) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        data_m[n] = '0;
        cnt_m[n]  = '0;
      end
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h0);
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("rst_data%0d", n), 32'(od[n]), 32'h0);
        chk($sformatf("rst_cnt%0d", n), 32'(oc[n]), 32'h0);
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("valid%0d", n), 32'(out_valid[n]), 32'(q[n].size() != 0));
        chk($sformatf("data%0d", n), 32'(od[n]), 32'(data_m[n]));
        chk($sformatf("cnt%0d", n), 32'(oc[n]), 32'(cnt_m[n]));
      end
      c  = ch_of(in_sel);
      er = !flush && (q[c].size() == 0 || out_ready[c]);
      chk("in_ready", 32'(in_ready), 32'(er));
      if (flush) begin
        for (int n = 0; n < 4; n++) q[n].delete();
      end else begin
        for (int n = 0; n < 4; n++) begin
          if (q[n].size() != 0 && out_ready[n]) begin
            w = q[n].pop_front();
            chk($sformatf("drain%0d", n), 32'(od[n]), 32'(w));
            cnt_m[n] = cnt_m[n] + CNT_W'(1);
          end
        end
        if (in_valid && er) begin
          q[c].push_back(in_data);
          data_m[c] = in_data;
        end
      end
    end
  end

  typedef struct {
    logic       fl;
    logic [1:0] sel;
    logic [3:0] d;
    logic       v;
    logic [3:0] rdy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fl, input logic [1:0] sel, input logic [3:0] d,
                              input logic v, input logic [3:0] rdy, input logic er,
                              input logic [3:0] ov);
    vec_t t;
    t.fl = fl; t.sel = sel; t.d = d; t.v = v; t.rdy = rdy; t.exp_rdy = er; t.exp_ov = ov;
    return t;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rstb = 1'b0; flush = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;

    //            fl  sel    d     v   rdy      er  ov
    tbl.push_back(mk(0, 2'b00, 4'h5, 1, 4'b0000, 1, 4'b1000)); // route to ch3
    tbl.push_back(mk(0, 2'b00, 4'hA, 1, 4'b0000, 0, 4'b1000)); // ch3 full: stall
    tbl.push_back(mk(0, 2'b00, 4'h3, 1, 4'b1000, 1, 4'b1000)); // drain+refill ch3
    tbl.push_back(mk(0, 2'b01, 4'h2, 1, 4'b0000, 1, 4'b1100));
    tbl.push_back(mk(0, 2'b10, 4'h1, 1, 4'b0000, 1, 4'b1110));
    tbl.push_back(mk(0, 2'b11, 4'h0, 1, 4'b0000, 1, 4'b1111));
    tbl.push_back(mk(0, 2'b00, 4'h0, 0, 4'b1111, 1, 4'b0000)); // parallel drain
    tbl.push_back(mk(0, 2'b10, 4'hC, 1, 4'b0000, 1, 4'b0010));
    tbl.push_back(mk(1, 2'b10, 4'hD, 1, 4'b0010, 0, 4'b0000)); // flush wins
    tbl.push_back(mk(0, 2'b10, 4'h0, 0, 4'b0000, 1, 4'b0000));
    tbl.push_back(mk(0, 2'b11, 4'h7, 1, 4'b0000, 1, 4'b0001));
    tbl.push_back(mk(0, 2'b11, 4'h8, 1, 4'b0001, 1, 4'b0001));
    tbl.push_back(mk(0, 2'b11, 4'h0, 0, 4'b0001, 1, 4'b0000));

    repeat (3) tick();
    rstb = 1'b1;

    foreach (tbl[i]) begin
      flush = tbl[i].fl; in_sel = tbl[i].sel; in_data = tbl[i].d;
      in_valid = tbl[i].v; out_ready = tbl[i].rdy;
      #3;
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = '0;

    chk("flush_keeps_data1", 32'(out_data1), 32'hC);
    chk("tbl_cnt3", 32'(cnt3), 32'd2);
    chk("tbl_cnt2", 32'(cnt2), 32'd1);
    chk("tbl_cnt1", 32'(cnt1), 32'd1);
    chk("tbl_cnt0", 32'(cnt0), 32'd3);

    // Reset mid-stream with 4'hA held on ch2.
    in_sel = 2'b01; in_data = 4'hA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("hold_a_valid", 32'(out_valid), 32'b0100);
    chk("hold_a_data2", 32'(out_data2), 32'hA);
    in_sel = 2'b00;
    #2;
    rstb = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data2", 32'(out_data2), 32'h0);
    chk("async_rst_cnt3", 32'(cnt3), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    in_sel = 2'b11; in_data = 4'h3; in_valid = 1'b1;
    rstb = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_accept_valid", 32'(out_valid), 32'b0001);
    chk("first_accept_data0", 32'(out_data0), 32'h3);
    out_ready = 4'b0001;
    tick();
    chk("first_drain_cnt0", 32'(cnt0), 32'd1);

    // Back-to-back throughput on ch0, from a clean reset.
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    out_ready = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      in_sel = 2'b11; in_data = 4'(i); in_valid = 1'b1;
      #3;
      chk($sformatf("tput%0d_ready", i), 32'(in_ready), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("tput_cnt0", 32'(cnt0), 32'd8);
    chk("tput_empty", 32'(out_valid), 32'h0);

    // Counter wrap on ch0.
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    out_ready = 4'b0001;
    for (int i = 1; i <= 256; i++) begin
      in_sel = 2'b11; in_data = 4'(i); in_valid = 1'b1;
      tick();
      if (i == 256) chk("wrap_cnt0_255", 32'(cnt0), 32'd255);
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt0_0", 32'(cnt0), 32'd0);
    out_ready = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
